// File: rtl/if_fetch_ctrl_if.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl_if
//   Bundles the two handshakes owned by the instruction-fetch controller:
//     * the instruction-memory read port (req/addr out, ack/rdata back)
//     * the IF/ID pipeline slot (valid/pc/instr out, stall back)
//   Signal suffixes are written from the controller's point of view, so the
//   controller connects through the master modport and the memory/decode
//   side (or a testbench) through the slave modport.
//
//   imem_req_o    controller -> imem    read request, held until acked
//   imem_addr_o   controller -> imem    read address, stable while requesting
//   imem_ack_i    imem -> controller    read data valid (only while requested)
//   imem_rdata_i  imem -> controller    read data, valid with imem_ack_i
//   id_stall_i    decode -> controller  decode cannot accept the slot
//   if_valid_o    controller -> decode  slot holds a valid instruction
//   if_pc_o       controller -> decode  PC of the slot instruction
//   if_instr_o    controller -> decode  slot instruction word
// ----------------------------------------------------------------------------
interface if_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack_i;
  logic [DATA_W-1:0] imem_rdata_i;

  logic              id_stall_i;
  logic              if_valid_o;
  logic [ADDR_W-1:0] if_pc_o;
  logic [DATA_W-1:0] if_instr_o;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i,
    input  id_stall_i,
    output if_valid_o,
    output if_pc_o,
    output if_instr_o
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i,
    output id_stall_i,
    input  if_valid_o,
    input  if_pc_o,
    input  if_instr_o
  );

endinterface

// File: rtl/if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl
//   Instruction-fetch controller sitting between the PC register and a
//   variable-latency instruction memory. It issues one read at the current PC,
//   advances the PC (pc_write_o) only when a fetch is actually accepted or a
//   redirect arrives, and presents fetched instructions to the IF/ID slot with
//   a valid/stall handshake. A one-entry skid register absorbs the ack that
//   lands while decode is stalled, so no fetched word is ever lost.
//
//   Ports
//     clk_i       in   rising-edge clock
//     rst_i       in   asynchronous, active-low reset
//     start_i     in   run enable; low stops issuing new fetches
//     pc_i        in   current PC register value
//     pc_write_o  out  PC load enable (combinational)
//     flush_i     in   redirect; upstream mux presents the target to the PC
//     bus         --   imem read port + IF/ID slot (master modport)
//
//   States
//     IDLE   no request outstanding
//     FETCH  request at pc_i outstanding (PC frozen until ack)
//     DROP   request abandoned by a redirect; still held at its original
//            address until the memory acks, then its data is thrown away
//     HOLD   slot occupied and stalled, fetched word parked in the skid reg
// ----------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_write_o,
  input  logic              flush_i,
  if_fetch_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  // Address of a request that was overtaken by a redirect. The memory still
  // owns that request, so the address must stay on the bus until it acks,
  // even though pc_i has already moved to the redirect target.
  logic [ADDR_W-1:0] r_drop_addr;

  // Skid entry: word acked while the slot was occupied and stalled.
  logic [ADDR_W-1:0] r_skid_pc;
  logic [DATA_W-1:0] r_skid_instr;

  // IF/ID slot.
  logic              r_valid;
  logic [ADDR_W-1:0] r_slot_pc;
  logic [DATA_W-1:0] r_slot_instr;

  // Decoded control strobes (output process).
  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic              w_pc_write;
  logic              w_load_slot;    // acked word goes straight to the slot
  logic              w_load_skid;    // acked word parked, slot is blocked
  logic              w_skid_to_slot; // stall released, skid moves to slot
  logic              w_cap_drop;     // remember address of abandoned request

  logic              w_slot_free;
  logic              w_ack;

  // The slot can take a new word if it is empty or decode consumes it now.
  assign w_slot_free = !r_valid || !bus.id_stall_i;

  // Ack is only meaningful while a request is on the bus.
  assign w_ack = bus.imem_ack_i && w_req;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        if (bus.imem_ack_i) begin
          // A blocked slot only matters when the word is kept; a flushed
          // ack is discarded and never needs the skid entry.
          if (!flush_i && !w_slot_free) begin
            w_state_next = S_HOLD;
          end else begin
            w_state_next = start_i ? S_FETCH : S_IDLE;
          end
        end else if (flush_i) begin
          w_state_next = S_DROP;
        end
      end

      S_DROP: begin
        // Further redirects while dropping keep waiting for the same ack.
        if (bus.imem_ack_i) begin
          w_state_next = start_i ? S_FETCH : S_IDLE;
        end
      end

      S_HOLD: begin
        if (flush_i || !bus.id_stall_i) begin
          w_state_next = start_i ? S_FETCH : S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_req          = 1'b0;
    w_addr         = '0;
    w_pc_write     = 1'b0;
    w_load_slot    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_slot = 1'b0;
    w_cap_drop     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_pc_write = flush_i;
      end

      S_FETCH: begin
        // pc_i is stable here: the PC only advances in the ack cycle.
        w_req  = 1'b1;
        w_addr = pc_i;
        if (flush_i) begin
          // Redirect wins. If the ack lands in the same cycle its data is
          // simply ignored; otherwise the request continues in DROP.
          w_pc_write = 1'b1;
          w_cap_drop = !bus.imem_ack_i;
        end else if (bus.imem_ack_i) begin
          w_pc_write  = 1'b1;
          w_load_slot = w_slot_free;
          w_load_skid = !w_slot_free;
        end
      end

      S_DROP: begin
        w_req      = 1'b1;
        w_addr     = r_drop_addr;
        w_pc_write = flush_i;
      end

      S_HOLD: begin
        w_pc_write     = flush_i;
        w_skid_to_slot = !flush_i && !bus.id_stall_i;
      end

      default: begin
        w_req = 1'b0;
      end
    endcase
  end

  // pc_write_o is combinational from flush_i, so it is also masked by reset
  // to keep the PC frozen while the controller is held in reset.
  assign pc_write_o      = w_pc_write && rst_i;
  assign bus.imem_req_o  = w_req;
  assign bus.imem_addr_o = w_addr;

  // --------------------------------------------------------------------------
  // Drop address and skid entry
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_drop_addr  <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else begin
      if (w_cap_drop) begin
        r_drop_addr <= pc_i;
      end
      if (w_load_skid && w_ack) begin
        r_skid_pc    <= pc_i;
        r_skid_instr <= bus.imem_rdata_i;
      end
    end
  end

  // --------------------------------------------------------------------------
  // IF/ID slot
  //   Priority: redirect clears, then a new word loads, then a consumed word
  //   retires. While decode stalls and nothing loads, contents are held.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid      <= 1'b0;
      r_slot_pc    <= '0;
      r_slot_instr <= '0;
    end else begin
      if (flush_i) begin
        r_valid <= 1'b0;
      end else if (w_load_slot && w_ack) begin
        r_valid      <= 1'b1;
        r_slot_pc    <= pc_i;
        r_slot_instr <= bus.imem_rdata_i;
      end else if (w_skid_to_slot) begin
        r_valid      <= 1'b1;
        r_slot_pc    <= r_skid_pc;
        r_slot_instr <= r_skid_instr;
      end else if (!bus.id_stall_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.if_valid_o = r_valid;
  assign bus.if_pc_o    = r_slot_pc;
  assign bus.if_instr_o = r_slot_instr;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_ctrl
//   Drives the fetch controller with a behavioural PC register and a
//   random-latency instruction memory, and checks it against a transaction
//   model:
//     * a request lives from req rising to its ack; it is discarded if a
//       redirect is seen in any cycle of its life, otherwise it is accepted
//     * pc_write must be exactly (redirect | accepted ack)
//     * accepted PCs enter an in-order queue of words owed to decode; the
//       head of the queue is what the IF/ID slot must show; decode
//       consumption pops it, a redirect empties it; at most two words
//       (slot + parked) may be owed, and with two owed no request may run
//     * a request holds req/addr until ack, starts at pc_i, and only starts
//       if start_i was high in the previous cycle
// ----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_write_o;
  logic        flush_i = 1'b0;

  if_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .pc_i       (pc_i),
    .pc_write_o (pc_write_o),
    .flush_i    (flush_i),
    .bus        (bus)
  );

  always #5 clk_i = ~clk_i;

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_consumed = 0;
  int          n_accept = 0;

  // Model state.
  logic [31:0] tb_pc = '0;
  logic [31:0] q[$];
  bit          cont = 1'b0;
  bit          tainted = 1'b0;
  int          wait_left = 0;
  logic [31:0] req_addr = '0;
  bit          prev_start = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive at the falling edge, answer the memory, check,
  // then advance the model to what must hold after the next rising edge.
  // lat < 0 picks a random latency (0..3) for a request that starts here.
  task automatic step(input bit st, input bit fl, input bit stl, input int lat,
                      input logic [31:0] tgt);
    bit new_req;
    bit ack;
    bit accept;
    bit exp_pw;
    @(negedge clk_i);
    start_i          = st;
    flush_i          = fl;
    bus.id_stall_i   = stl;
    pc_i             = tb_pc;
    bus.imem_ack_i   = 1'b0;
    bus.imem_rdata_i = $urandom;
    #1;
    new_req = bus.imem_req_o && !cont;
    if (cont) begin
      chk("req_held", bus.imem_req_o, 1);
      chk("addr_held", bus.imem_addr_o, req_addr);
    end
    if (new_req) begin
      chk("req_needs_start", prev_start, 1);
      chk("req_addr_is_pc", bus.imem_addr_o, pc_i);
      req_addr  = bus.imem_addr_o;
      wait_left = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      tainted   = 1'b0;
    end
    ack = bus.imem_req_o && (wait_left == 0);
    bus.imem_ack_i = ack;
    if (ack) bus.imem_rdata_i = mem_word(bus.imem_addr_o);
    #1;
    if (bus.imem_req_o && fl) tainted = 1'b1;
    accept = ack && !tainted;
    exp_pw = fl || accept;
    chk("pc_write", pc_write_o, exp_pw);
    chk("if_valid", bus.if_valid_o, q.size() != 0);
    if (q.size() != 0) begin
      chk("if_pc", bus.if_pc_o, q[0]);
      chk("if_instr", bus.if_instr_o, mem_word(q[0]));
    end
    if (q.size() >= 2) chk("hold_no_req", bus.imem_req_o, 0);
    $display("cyc t=%0t st=%0b fl=%0b stl=%0b req=%0b addr=%0h ack=%0b pcw=%0b v=%0b slot=%0h",
             $time, st, fl, stl, bus.imem_req_o, bus.imem_addr_o, ack, pc_write_o,
             bus.if_valid_o, bus.if_pc_o);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && !stl) begin
        void'(q.pop_front());
        n_consumed++;
      end
      if (accept) begin
        q.push_back(pc_i);
        n_accept++;
      end
    end
    cont = bus.imem_req_o && !ack;
    if (cont && wait_left > 0) wait_left--;
    if (fl) tb_pc = tgt;
    else if (exp_pw) tb_pc = tb_pc + 32'd4;
    prev_start = st;
  endtask

  task automatic model_reset();
    q.delete();
    cont       = 1'b0;
    tainted    = 1'b0;
    wait_left  = 0;
    prev_start = 1'b0;
  endtask

  initial begin
    int base;
    bus.imem_ack_i   = 1'b0;
    bus.imem_rdata_i = '0;
    bus.id_stall_i   = 1'b0;

    // Reset state (redirect held high to show pc_write stays masked).
    flush_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_req", bus.imem_req_o, 0);
    chk("rst_addr", bus.imem_addr_o, 0);
    chk("rst_valid", bus.if_valid_o, 0);
    chk("rst_pc_write", pc_write_o, 0);
    chk("rst_if_pc", bus.if_pc_o, 0);
    chk("rst_if_instr", bus.if_instr_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0;
    rst_i   = 1'b1;
    model_reset();

    // Zero-wait memory: one accepted fetch per cycle.
    step(1, 0, 0, 0, 0);
    base = n_accept;
    repeat (3) step(1, 0, 0, 0, 0);
    chk("zero_wait_rate", n_accept - base, 3);
    repeat (3) step(0, 0, 0, 0, 0);

    // Wait states at 0x10; start falls while the request is in flight.
    step(0, 1, 0, 0, 32'h10);
    step(1, 0, 0, 3, 0);
    repeat (6) step(0, 0, 0, 3, 0);
    chk("ws_word_seen", n_consumed >= 4, 1);

    // Redirect one cycle before the ack of a request at 0x20.
    step(0, 1, 0, 0, 32'h20);
    step(1, 0, 0, 2, 0);
    step(1, 0, 0, 2, 0);
    step(1, 1, 0, 2, 32'h80);
    repeat (6) step(1, 0, 0, 2, 0);
    repeat (4) step(0, 0, 0, 0, 0);

    // Redirect in the same cycle as the ack at 0x30.
    step(0, 1, 0, 0, 32'h30);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 32'h100);
    repeat (3) step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);

    // Back-pressure: slot holds 0x3C under stall when 0x40 is acked.
    step(0, 1, 0, 0, 32'h3C);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    repeat (2) step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 2) == 0, -1, $urandom & 32'hFFFF_FFFC);
    end

    // Asynchronous reset in the middle of an outstanding request.
    step(1, 0, 0, 3, 0);
    step(1, 0, 0, 3, 0);
    @(posedge clk_i);
    #2;
    flush_i = 1'b1;
    rst_i   = 1'b0;
    #1;
    chk("arst_req", bus.imem_req_o, 0);
    chk("arst_valid", bus.if_valid_o, 0);
    chk("arst_pc_write", pc_write_o, 0);
    @(negedge clk_i);
    flush_i        = 1'b0;
    start_i        = 1'b0;
    bus.imem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("arst_if_pc", bus.if_pc_o, 0);
    rst_i = 1'b1;
    model_reset();
    step(1, 0, 0, 0, 0);
    base = n_accept;
    step(1, 0, 0, 0, 0);
    chk("resume_fetch", n_accept - base, 1);

    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, -1, $urandom & 32'hFFFF_FFFC);
    end

    // Drain: nothing owed, bus quiet.
    repeat (10) step(0, 0, 0, -1, 0);
    chk("drain_valid", bus.if_valid_o, 0);
    chk("drain_req", bus.imem_req_o, 0);
    chk("progress", n_consumed > 100, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
